led_zone_sender: RTL and testbench
==================================

Name: led_zone_sender

Overview:
- Downstream consumer of the per-zone grey-maximum statistics produced by the RGB-to-grey zoning stage.
- Captures one 8-bit brightness value per backlight zone into a ping-pong buffer, written during the frame.
- On each end-of-frame pulse, the buffers swap and the completed frame is shifted out MSB-first to the LED driver chain, followed by a latch pulse.
- Sits between the zone statistics stage and the off-chip LED constant-current drivers.

Parameters:
- N_ZONES, 360, number of zones per frame (24 x 15); addresses 0..N_ZONES-1.
- CLK_DIV, 2, I_pix_clk cycles per SCLK half-period (>=1).
- AW, 9, zone address width (must cover N_ZONES-1).

Ports:
- I_pix_clk  in  1  pixel clock; the only clock.
- I_rst  in  1  synchronous reset, active-high.
- I_zone_we  in  1  write strobe for one zone value.
- I_zone_addr  in  AW  zone index written.
- I_zone_data  in  8  zone brightness (grey max).
- I_frame_done  in  1  single-cycle pulse: upstream finished all zones of the frame.
- I_floor  in  8  minimum output brightness; sampled when a frame is accepted.
- O_led_sclk  out  1  serial clock to the LED drivers.
- O_led_sdi  out  1  serial data, MSB first, zone 0 first.
- O_led_le  out  1  latch enable; high for CLK_DIV cycles after the last bit.
- O_busy  out  1  a transfer is in progress.
- O_drop  out  1  one-cycle pulse: frame_done arrived while busy, so the frame was discarded.

Behaviour:
- Reset (I_rst high at a clock edge): all outputs 0, FSM to IDLE, write bank = 0, and any transfer is aborted immediately. RAM contents are not cleared.
- Buffer: two banks of N_ZONES x 8. Writes always go to the write bank. A write with addr >= N_ZONES is ignored. Each write is one cycle, with no back-pressure.
- Frame accept: I_frame_done in IDLE at cycle T:
  - the write bank toggles at T+1, and the old write bank becomes the read bank;
  - floor_r <= I_floor;
  - zone counter = 0;
  - FSM goes to LOAD; O_busy = 1 from T+1.
- A write in the same cycle as an accepted I_frame_done lands in the old bank, which is then sent.
- I_frame_done while not IDLE: O_drop pulses for 1 cycle, with no swap and no effect on the transfer. That frame's writes remain in the write bank and are overwritten by the next frame.
- States:
  - IDLE: SCLK = 0, SDI = 0, LE = 0.
  - LOAD (1 cycle): issue synchronous RAM read of the read bank at the zone counter. The value arrives the next cycle, with out = max(data, floor_r) loaded into an 8-bit shift register; go to SHIFT_LO.
  - SHIFT_LO (CLK_DIV cycles): SCLK = 0, SDI = shreg[7].
  - SHIFT_HI (CLK_DIV cycles): SCLK = 1, SDI held. Then:
    - if bit count < 7: shift left, go to SHIFT_LO;
    - else if zone < N_ZONES-1: zone++, go to LOAD;
    - else: go to LATCH.
  - LATCH (CLK_DIV cycles): SCLK = 0, SDI = 0, LE = 1, then return to IDLE with O_busy = 0.
- SDI changes only while SCLK is low; the driver samples on the SCLK rising edge.
- Transfer length from T+1 to the last LE cycle inclusive: N_ZONES*(1+16*CLK_DIV)+CLK_DIV cycles. With the defaults this is 360*33+2 = 11882.
- Ties: floor and data equal -> that value is sent. A floor of 0 passes data unchanged.
- All outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
- Reset then idle: hold I_rst 3 cycles, no stimulus -> SCLK/SDI/LE/O_busy/O_drop all 0, and they stay 0 for 100 cycles.
- Basic frame (N_ZONES=4, CLK_DIV=2, floor 0): write zones 0..3 = 8'hA5, 8'h00, 8'hFF, 8'h3C, then pulse frame_done -> 32 SCLK rising edges capture A5 00 FF 3C. LE is high for 2 cycles. O_busy lasts 4*33+2 = 134 cycles.
- Floor clamp: same data, I_floor = 8'h40 -> bytes sent are A5 40 FF 40.
- Overrun: pulse frame_done again 20 cycles into the transfer -> O_drop is one 1-cycle pulse and the stream is unchanged. The next accepted frame sends the bank with the frame's new writes.
- Ping-pong isolation and address range: during a transfer, write zone 1 = 8'h77 and addr 5 = 8'h11 -> the current stream is unaffected. The next frame sends 8'h77 at zone 1, and addr 5 is never stored.
- Reset mid-transfer: assert I_rst at bit 3 of zone 2 -> next cycle all outputs are 0 and the FSM is IDLE. A following frame_done starts a full transfer from zone 0.

Source files
------------

// File: rtl/led_zone_sender.sv
// led_zone_sender: collects one brightness byte per backlight zone into a
// ping-pong buffer and, on each accepted frame_done, shifts the finished frame
// out MSB-first to the LED driver chain, followed by a latch pulse.
module led_zone_sender #(
    parameter int unsigned N_ZONES = 360,
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned AW      = 9
) (
    input  logic          I_pix_clk,
    input  logic          I_rst,
    input  logic          I_zone_we,
    input  logic [AW-1:0] I_zone_addr,
    input  logic [7:0]    I_zone_data,
    input  logic          I_frame_done,
    input  logic [7:0]    I_floor,
    output logic          O_led_sclk,
    output logic          O_led_sdi,
    output logic          O_led_le,
    output logic          O_busy,
    output logic          O_drop
);
    localparam int unsigned DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DEPTH = 2 * (1 << AW);
    localparam logic [AW-1:0] LAST_ZONE = AW'(N_ZONES - 1);
    localparam logic [DW-1:0] LAST_DIV  = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t        state, state_n;
    logic          wr_bank, wr_bank_n;
    logic [7:0]    floor_r, floor_n;
    logic [AW-1:0] zone, zone_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [DW-1:0] div_cnt, div_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    rd_data;
    logic [7:0]    clamp;
    logic          rd_bank;
    logic          wr_ok;
    logic          fwd;

    // Both banks live in one array indexed by {bank, addr}
    logic [7:0] mem [DEPTH];

    assign wr_ok   = I_zone_we && (32'(I_zone_addr) < N_ZONES);
    assign rd_bank = ~wr_bank_n;
    // A write landing in the bank being read on the accept edge must be seen
    assign fwd     = wr_ok && (wr_bank == rd_bank) && (I_zone_addr == zone_n);
    assign clamp   = (rd_data > floor_r) ? rd_data : floor_r;

    // Zone RAM: write port into the write bank, registered read of the read bank
    always_ff @(posedge I_pix_clk) begin
        if (wr_ok) begin
            mem[{wr_bank, I_zone_addr}] <= I_zone_data;
        end
        if (state_n == LOAD) begin
            rd_data <= fwd ? I_zone_data : mem[{rd_bank, zone_n}];
        end
    end

    // FSM state register
    always_ff @(posedge I_pix_clk) begin
        if (I_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_n   = state;
        wr_bank_n = wr_bank;
        floor_n   = floor_r;
        zone_n    = zone;
        bit_n     = bit_cnt;
        div_n     = div_cnt;
        shreg_n   = shreg;
        case (state)
            IDLE: begin
                if (I_frame_done) begin
                    state_n   = LOAD;
                    wr_bank_n = ~wr_bank;
                    floor_n   = I_floor;
                    zone_n    = '0;
                end
            end
            LOAD: begin
                shreg_n = clamp;
                bit_n   = '0;
                div_n   = '0;
                state_n = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (div_cnt == LAST_DIV) begin
                    div_n   = '0;
                    state_n = SHIFT_HI;
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            SHIFT_HI: begin
                if (div_cnt == LAST_DIV) begin
                    div_n = '0;
                    if (bit_cnt != 3'd7) begin
                        bit_n   = bit_cnt + 3'd1;
                        shreg_n = {shreg[6:0], 1'b0};
                        state_n = SHIFT_LO;
                    end else if (zone != LAST_ZONE) begin
                        zone_n  = zone + AW'(1);
                        state_n = LOAD;
                    end else begin
                        state_n = LATCH;
                    end
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            LATCH: begin
                if (div_cnt == LAST_DIV) begin
                    div_n   = '0;
                    state_n = IDLE;
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath registers and registered outputs derived from the next state
    always_ff @(posedge I_pix_clk) begin
        if (I_rst) begin
            wr_bank    <= 1'b0;
            floor_r    <= '0;
            zone       <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            shreg      <= '0;
            O_led_sclk <= 1'b0;
            O_led_sdi  <= 1'b0;
            O_led_le   <= 1'b0;
            O_busy     <= 1'b0;
            O_drop     <= 1'b0;
        end else begin
            wr_bank    <= wr_bank_n;
            floor_r    <= floor_n;
            zone       <= zone_n;
            bit_cnt    <= bit_n;
            div_cnt    <= div_n;
            shreg      <= shreg_n;
            O_led_sclk <= (state_n == SHIFT_HI);
            O_led_sdi  <= ((state_n == SHIFT_LO) || (state_n == SHIFT_HI)) && shreg_n[7];
            O_led_le   <= (state_n == LATCH);
            O_busy     <= (state_n != IDLE);
            O_drop     <= I_frame_done && (state != IDLE);
        end
    end

endmodule

// File: tb/tb_led_zone_sender.sv
// tb_led_zone_sender: scenario bench for led_zone_sender with a byte scoreboard
// fed from a behavioural ping-pong buffer model.
module tb_led_zone_sender;
    localparam int unsigned NZ  = 4;
    localparam int unsigned CD  = 2;
    localparam int unsigned AWB = 9;
    localparam int BUSY_LEN = NZ * (1 + 16 * CD) + CD;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           zone_we = 1'b0;
    logic [AWB-1:0] zone_addr = '0;
    logic [7:0]     zone_data = '0;
    logic           frame_done = 1'b0;
    logic [7:0]     floor_in = '0;
    logic           sclk, sdi, le, busy, drop;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_mem [2][NZ];
    logic       model_wb = 1'b0;
    logic [7:0] exp_q [$];

    logic       prev_sclk = 1'b0;
    logic       prev_sdi  = 1'b0;
    logic [7:0] sh = '0;
    logic [7:0] e_byte;
    int nbits = 0, rise_cnt = 0, busy_cnt = 0, le_cnt = 0, drop_cnt = 0;

    led_zone_sender #(.N_ZONES(NZ), .CLK_DIV(CD), .AW(AWB)) dut (
        .I_pix_clk   (clk),
        .I_rst       (rst),
        .I_zone_we   (zone_we),
        .I_zone_addr (zone_addr),
        .I_zone_data (zone_data),
        .I_frame_done(frame_done),
        .I_floor     (floor_in),
        .O_led_sclk  (sclk),
        .O_led_sdi   (sdi),
        .O_led_le    (le),
        .O_busy      (busy),
        .O_drop      (drop)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mx(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // Serial receiver: captures bytes on SCLK rising, checks them against the queue
    always @(negedge clk) begin
        if (rst) begin
            nbits = 0;
        end else begin
            if (sclk) begin
                n_checks++;
                if (sdi !== prev_sdi) begin
                    n_fail++;
                    $display("FAIL sdi_stable: sdi=%b while sclk high, required %b", sdi, prev_sdi);
                end
            end
            if (sclk && !prev_sclk) begin
                sh = {sh[6:0], sdi};
                nbits++;
                rise_cnt++;
                if (nbits == 8) begin
                    nbits = 0;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL stream_byte: got %h, no byte expected", sh);
                    end else begin
                        e_byte = exp_q.pop_front();
                        if (sh !== e_byte) begin
                            n_fail++;
                            $display("FAIL stream_byte: got %h, required %h", sh, e_byte);
                        end
                    end
                end
            end
        end
        if (busy) busy_cnt++;
        if (le)   le_cnt++;
        if (drop) drop_cnt++;
        prev_sclk = sclk;
        prev_sdi  = sdi;
    end

    task automatic write_zone(input logic [AWB-1:0] a, input logic [7:0] d);
        @(negedge clk);
        zone_we = 1'b1; zone_addr = a; zone_data = d;
        @(negedge clk);
        zone_we = 1'b0;
        if (32'(a) < NZ) model_mem[model_wb][a] = d;
    endtask

    task automatic write_frame(input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3);
        write_zone(AWB'(0), d0);
        write_zone(AWB'(1), d1);
        write_zone(AWB'(2), d2);
        write_zone(AWB'(3), d3);
    endtask

    // Pulse frame_done, predict the stream, and follow the transfer to its end
    task automatic send_frame(input logic [7:0] flr, input int ovr_at, input bit mid_wr,
                              input bit rst_mid, input bit same_we, input logic [7:0] same_d);
        bit finished;
        finished = 1'b0;
        if (same_we) model_mem[model_wb][0] = same_d;
        for (int z = 0; z < NZ; z++) exp_q.push_back(mx(model_mem[model_wb][z], flr));
        busy_cnt = 0; le_cnt = 0; drop_cnt = 0; rise_cnt = 0;
        @(negedge clk);
        frame_done = 1'b1; floor_in = flr;
        if (same_we) begin zone_we = 1'b1; zone_addr = '0; zone_data = same_d; end
        @(negedge clk);
        frame_done = 1'b0; zone_we = 1'b0; floor_in = ~flr;
        model_wb = ~model_wb;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (!busy) begin finished = 1'b1; break; end
            frame_done = (c == ovr_at);
            if (mid_wr) begin
                if (c == 30) begin
                    zone_we = 1'b1; zone_addr = AWB'(1); zone_data = 8'h77;
                    model_mem[model_wb][1] = 8'h77;
                end else if (c == 31) begin
                    zone_we = 1'b1; zone_addr = AWB'(5); zone_data = 8'h11;
                end else if (c == 32) begin
                    zone_we = 1'b0;
                end
            end
            if (rst_mid && rise_cnt >= 19) begin
                rst = 1'b1; frame_done = 1'b0; zone_we = 1'b0;
                @(negedge clk);
                n_checks++;
                if ({sclk, sdi, le, busy, drop} !== 5'b0) begin
                    n_fail++;
                    $display("FAIL reset_abort: outputs %b, required 00000", {sclk, sdi, le, busy, drop});
                end
                rst = 1'b0;
                exp_q.delete();
                model_wb = 1'b0;
                return;
            end
        end
        frame_done = 1'b0;
        n_checks++;
        if (!finished) begin
            n_fail++;
            $display("FAIL transfer_timeout: busy still %b after 1000 cycles, required 0", busy);
        end
        n_checks++;
        if (busy_cnt !== BUSY_LEN) begin
            n_fail++;
            $display("FAIL busy_length: %0d cycles, required %0d", busy_cnt, BUSY_LEN);
        end
        n_checks++;
        if (le_cnt !== CD) begin
            n_fail++;
            $display("FAIL le_length: %0d cycles, required %0d", le_cnt, CD);
        end
        n_checks++;
        if (drop_cnt !== ((ovr_at > 0) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL drop_count: %0d cycles, required %0d", drop_cnt, (ovr_at > 0) ? 1 : 0);
        end
        n_checks++;
        if (exp_q.size() != 0 || nbits != 0) begin
            n_fail++;
            $display("FAIL stream_length: %0d bytes missing, %0d stray bits, required 0 and 0",
                     exp_q.size(), nbits);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_checks++;
            if ({sclk, sdi, le, busy, drop} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_idle: cycle %0d outputs %b, required 00000", i, {sclk, sdi, le, busy, drop});
            end
        end
    endtask

    task automatic test_basic();
        write_frame(8'hA5, 8'h00, 8'hFF, 8'h3C);
        send_frame(8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_floor();
        write_frame(8'hA5, 8'h00, 8'hFF, 8'h3C);
        send_frame(8'h40, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_overrun();
        write_frame(8'h11, 8'h22, 8'h33, 8'h44);
        send_frame(8'h00, 20, 1'b0, 1'b0, 1'b0, 8'h00);
        write_frame(8'h55, 8'h66, 8'h77, 8'h88);
        send_frame(8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_pingpong();
        write_frame(8'h01, 8'h02, 8'h03, 8'h04);
        send_frame(8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00);
        send_frame(8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid();
        write_frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        send_frame(8'h00, 0, 1'b0, 1'b1, 1'b0, 8'h00);
        send_frame(8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_same_cycle_write();
        send_frame(8'h00, 0, 1'b0, 1'b0, 1'b1, 8'h5A);
    endtask

    task automatic test_ties();
        write_frame(8'h80, 8'h7F, 8'h00, 8'hFF);
        send_frame(8'h80, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_floor();
        test_overrun();
        test_pingpong();
        test_reset_mid();
        test_same_cycle_write();
        test_ties();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
